// File: rtl/dla_mov_gb2lb.sv
// GB->LB move engine: streams len x iter words from the global buffer into the local buffer.
// Optional transfer cycle counter enabled by defining DLA_MOV_GB2LB_PERF_EN.
module dla_mov_gb2lb #(
  parameter int DW     = 64,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_mov_gb2lb,
  input  logic [12:0]       stgr_gb2lb_gb_addr,
  input  logic [12:0]       stgr_gb2lb_gb_skip,
  input  logic [10:0]       stgr_gb2lb_lb_addr,
  input  logic [5:0]        stgr_gb2lb_lb_skip,
  input  logic [12:0]       stgr_gb2lb_len,
  input  logic [5:0]        stgr_gb2lb_iter,
  output logic              gb_ren,
  input  logic              gb_gnt,
  output logic [12:0]       gb_raddr,
  input  logic [DW-1:0]     gb_rdata,
  output logic              lb_wen,
  output logic [10:0]       lb_waddr,
  output logic [DW-1:0]     lb_wdata,
  output logic              busy,
  output logic              done,
  output logic              ovr,
  output logic [PERF_W-1:0] perf_cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [12:0] gb_skip_r;
  logic [5:0]  lb_skip_r;
  logic [12:0] len_r;
  logic [5:0]  iter_r;
  logic [12:0] row_gb;
  logic [10:0] row_lb;
  logic [12:0] wcnt;
  logic [5:0]  rcnt;
  logic        accept;
  logic        last_word;
  logic        last_row;

  logic              vld_p0;
  logic [10:0]       waddr_p0;
  logic [DW-1:0]     wdata_hold;

  assign accept    = (state == RUN) && gb_gnt;
  assign last_word = (wcnt == len_r - 13'd1);
  assign last_row  = (rcnt == iter_r - 6'd1);

  assign gb_ren   = (state == RUN);
  assign gb_raddr = row_gb + wcnt;
  assign busy     = (state == LOAD) || (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign ovr      = go_mov_gb2lb && busy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_mov_gb2lb) state_nxt = LOAD;
      LOAD:    state_nxt = ((stgr_gb2lb_len == 13'd0) || (stgr_gb2lb_iter == 6'd0)) ? DONE : RUN;
      RUN:     if (accept && last_word && last_row) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = go_mov_gb2lb ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer parameters are frozen in LOAD so later staging-register changes are invisible.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      gb_skip_r <= stgr_gb2lb_gb_skip;
      lb_skip_r <= stgr_gb2lb_lb_skip;
      len_r     <= stgr_gb2lb_len;
      iter_r    <= stgr_gb2lb_iter;
    end
  end

  // Read stage: address walk and accept capture (p0 = write stage one cycle after accept)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row_gb     <= '0;
      row_lb     <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      vld_p0     <= 1'b0;
      waddr_p0   <= '0;
      wdata_hold <= '0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= accept;
      if (state == LOAD) begin
        row_gb <= stgr_gb2lb_gb_addr;
        row_lb <= stgr_gb2lb_lb_addr;
        wcnt   <= '0;
        rcnt   <= '0;
      end else if (accept) begin
        waddr_p0 <= row_lb + wcnt[10:0];
        if (last_word) begin
          wcnt   <= '0;
          rcnt   <= rcnt + 6'd1;
          row_gb <= row_gb + gb_skip_r;
          row_lb <= row_lb + {5'd0, lb_skip_r};
        end else begin
          wcnt <= wcnt + 13'd1;
        end
      end
      if (vld_p0) wdata_hold <= gb_rdata;
    end
  end

  // Write stage: read data arrives the cycle after accept and passes straight through.
  assign lb_wen   = vld_p0;
  assign lb_waddr = waddr_p0;
  assign lb_wdata = vld_p0 ? gb_rdata : wdata_hold;

`ifdef DLA_MOV_GB2LB_PERF_EN
  logic [PERF_W-1:0] perf_cnt;
  logic [PERF_W-1:0] perf_q;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  // LOAD counts as the first cycle so the latched value equals the go-to-done distance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
      perf_q   <= '0;
    end else begin
      case (state)
        LOAD:       perf_cnt <= PERF_W'(1);
        RUN, DRAIN: perf_cnt <= sat_inc(perf_cnt);
        DONE:       perf_q   <= sat_inc(perf_cnt);
        default:    perf_cnt <= perf_cnt;
      endcase
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_dla_mov_gb2lb.sv
// Directed self-checking bench for dla_mov_gb2lb; cycle 0 is the cycle go is driven.
module tb_dla_mov_gb2lb;

  logic        clk = 1'b0;
  logic        rst;
  logic        go_mov_gb2lb;
  logic [12:0] stgr_gb2lb_gb_addr;
  logic [12:0] stgr_gb2lb_gb_skip;
  logic [10:0] stgr_gb2lb_lb_addr;
  logic [5:0]  stgr_gb2lb_lb_skip;
  logic [12:0] stgr_gb2lb_len;
  logic [5:0]  stgr_gb2lb_iter;
  logic        gb_ren;
  logic        gb_gnt;
  logic [12:0] gb_raddr;
  logic [63:0] gb_rdata;
  logic        lb_wen;
  logic [10:0] lb_waddr;
  logic [63:0] lb_wdata;
  logic        busy;
  logic        done;
  logic        ovr;
  logic [15:0] perf_cycles;

  int checks = 0;
  int errors = 0;

  logic [12:0] rd_a[$];
  int          rd_c[$];
  logic [10:0] wr_a[$];
  logic [63:0] wr_d[$];
  int          wr_c[$];
  int          done_c, ovr_n, ovr_c, hold_chk, hold_bad;
  logic [63:0] busy_m;
  logic [3:0]  snap;

  dla_mov_gb2lb #(.DW(64), .PERF_W(16)) dut (
    .clk(clk), .rst(rst), .go_mov_gb2lb(go_mov_gb2lb),
    .stgr_gb2lb_gb_addr(stgr_gb2lb_gb_addr), .stgr_gb2lb_gb_skip(stgr_gb2lb_gb_skip),
    .stgr_gb2lb_lb_addr(stgr_gb2lb_lb_addr), .stgr_gb2lb_lb_skip(stgr_gb2lb_lb_skip),
    .stgr_gb2lb_len(stgr_gb2lb_len), .stgr_gb2lb_iter(stgr_gb2lb_iter),
    .gb_ren(gb_ren), .gb_gnt(gb_gnt), .gb_raddr(gb_raddr), .gb_rdata(gb_rdata),
    .lb_wen(lb_wen), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .busy(busy), .done(done), .ovr(ovr), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  // Drives one transfer and logs reads, writes, busy, done and ovr per cycle.
  // Read data model: word returned the cycle after accept = accepted address + 0xA00.
  task automatic run_xfer(input logic [12:0] ga, input logic [12:0] gs, input logic [10:0] la,
                          input logic [5:0] ls, input logic [12:0] ln, input logic [5:0] it,
                          input bit tgl, input int go2, input int rstc, input int maxc);
    logic [12:0] acc_a, prev_a;
    bit          acc_v, prev_wait;
    rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
    done_c = -1; ovr_n = 0; ovr_c = -1; hold_chk = 0; hold_bad = 0; busy_m = '0; snap = '0;
    acc_a = '0; prev_a = '0; acc_v = 1'b0; prev_wait = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      go_mov_gb2lb = (c == 0) || (c == go2);
      if (c <= 1) begin
        stgr_gb2lb_gb_addr = ga; stgr_gb2lb_gb_skip = gs; stgr_gb2lb_lb_addr = la;
        stgr_gb2lb_lb_skip = ls; stgr_gb2lb_len = ln; stgr_gb2lb_iter = it;
      end else begin
        stgr_gb2lb_gb_addr = ~ga; stgr_gb2lb_gb_skip = ~gs; stgr_gb2lb_lb_addr = ~la;
        stgr_gb2lb_lb_skip = ~ls; stgr_gb2lb_len = ~ln; stgr_gb2lb_iter = ~it;
      end
      gb_gnt   = tgl ? (c % 2 == 0) : 1'b1;
      gb_rdata = acc_v ? (64'(acc_a) + 64'hA00) : 64'hDEAD_BEEF;
      if (rstc >= 0 && c == rstc + 1) rst = 1'b0;
      if (c == rstc) begin #2; rst = 1'b1; end
      @(negedge clk);
      if (c == rstc) snap = {busy, gb_ren, lb_wen, done};
      if (gb_ren) begin
        if (prev_wait) begin
          hold_chk++;
          if (gb_raddr !== prev_a) hold_bad++;
        end
        if (gb_gnt) begin rd_a.push_back(gb_raddr); rd_c.push_back(c); end
      end
      prev_wait = gb_ren && !gb_gnt;
      prev_a    = gb_raddr;
      acc_v     = gb_ren && gb_gnt;
      acc_a     = gb_raddr;
      if (lb_wen) begin wr_a.push_back(lb_waddr); wr_d.push_back(lb_wdata); wr_c.push_back(c); end
      if (busy && c < 64) busy_m[c] = 1'b1;
      if (ovr) begin ovr_n++; ovr_c = c; end
      if (done && done_c < 0) done_c = c;
      @(posedge clk); #1;
      if (done_c >= 0) break;
    end
    go_mov_gb2lb = 1'b0;
    gb_gnt = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, ovr, gb_ren, lb_wen} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, ovr, gb_ren, lb_wen});
    end
    checks++;
    if ({gb_raddr, lb_waddr, lb_wdata, perf_cycles} !== '0) begin
      errors++; $display("FAIL reset_data got %0h/%0h/%0h/%0h exp 0", gb_raddr, lb_waddr, lb_wdata, perf_cycles);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    run_xfer(13'h010, 13'h000, 11'h020, 6'd0, 13'd4, 6'd1, 1'b0, -1, -1, 20);
    checks++;
    if (rd_a.size() != 4 || wr_a.size() != 4) begin
      errors++; $display("FAIL t1_count got rd=%0d wr=%0d exp 4/4", rd_a.size(), wr_a.size());
    end
    for (int i = 0; i < rd_a.size(); i++) begin
      checks++;
      if (rd_a[i] !== 13'h010 + 13'(i) || rd_c[i] != i + 2) begin
        errors++; $display("FAIL t1_rd%0d got %0h@%0d exp %0h@%0d", i, rd_a[i], rd_c[i], 13'h010 + 13'(i), i + 2);
      end
    end
    for (int i = 0; i < wr_a.size(); i++) begin
      checks++;
      if (wr_a[i] !== 11'h020 + 11'(i) || wr_d[i] !== 64'hA10 + 64'(i) || wr_c[i] != i + 3) begin
        errors++; $display("FAIL t1_wr%0d got %0h:%0h@%0d exp %0h:%0h@%0d", i, wr_a[i], wr_d[i], wr_c[i],
                           11'h020 + 11'(i), 64'hA10 + 64'(i), i + 3);
      end
    end
    checks++;
    if (done_c != 7 || busy_m !== 64'h7E || ovr_n != 0) begin
      errors++; $display("FAIL t1_ctrl got done@%0d busy=%0h ovr=%0d exp done@7 busy=7e ovr=0", done_c, busy_m, ovr_n);
    end
    checks++;
`ifdef DLA_MOV_GB2LB_PERF_EN
    if (perf_cycles !== 16'd7) begin errors++; $display("FAIL t1_perf got %0d exp 7", perf_cycles); end
`else
    if (perf_cycles !== 16'd0) begin errors++; $display("FAIL t1_perf got %0d exp 0", perf_cycles); end
`endif
  endtask

  task automatic test_multi_row();
    logic [12:0] er[6] = '{13'h000, 13'h001, 13'h002, 13'h100, 13'h101, 13'h102};
    logic [10:0] ew[6] = '{11'd0, 11'd1, 11'd2, 11'd8, 11'd9, 11'd10};
    run_xfer(13'h000, 13'h100, 11'h000, 6'd8, 13'd3, 6'd2, 1'b0, -1, -1, 20);
    checks++;
    if (rd_a.size() != 6 || wr_a.size() != 6) begin
      errors++; $display("FAIL t2_count got rd=%0d wr=%0d exp 6/6", rd_a.size(), wr_a.size());
    end
    for (int i = 0; i < rd_a.size() && i < 6; i++) begin
      checks++;
      if (rd_a[i] !== er[i] || rd_c[i] != i + 2) begin
        errors++; $display("FAIL t2_rd%0d got %0h@%0d exp %0h@%0d", i, rd_a[i], rd_c[i], er[i], i + 2);
      end
    end
    for (int i = 0; i < wr_a.size() && i < 6; i++) begin
      checks++;
      if (wr_a[i] !== ew[i] || wr_d[i] !== 64'(er[i]) + 64'hA00 || wr_c[i] != i + 3) begin
        errors++; $display("FAIL t2_wr%0d got %0h:%0h@%0d exp %0h:%0h@%0d", i, wr_a[i], wr_d[i], wr_c[i],
                           ew[i], 64'(er[i]) + 64'hA00, i + 3);
      end
    end
    checks++;
    if (done_c != 9) begin errors++; $display("FAIL t2_done got %0d exp 9", done_c); end
  endtask

  task automatic test_wrap();
    logic [12:0] er[4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    logic [10:0] ew[4] = '{11'h7FF, 11'h000, 11'h001, 11'h002};
    run_xfer(13'h1FFE, 13'h000, 11'h7FF, 6'd0, 13'd4, 6'd1, 1'b0, -1, -1, 20);
    checks++;
    if (rd_a.size() != 4 || wr_a.size() != 4) begin
      errors++; $display("FAIL t3_count got rd=%0d wr=%0d exp 4/4", rd_a.size(), wr_a.size());
    end
    for (int i = 0; i < rd_a.size() && i < 4; i++) begin
      checks++;
      if (rd_a[i] !== er[i]) begin errors++; $display("FAIL t3_rd%0d got %0h exp %0h", i, rd_a[i], er[i]); end
    end
    for (int i = 0; i < wr_a.size() && i < 4; i++) begin
      checks++;
      if (wr_a[i] !== ew[i] || wr_d[i] !== 64'(er[i]) + 64'hA00) begin
        errors++; $display("FAIL t3_wr%0d got %0h:%0h exp %0h:%0h", i, wr_a[i], wr_d[i], ew[i], 64'(er[i]) + 64'hA00);
      end
    end
  endtask

  task automatic test_gnt_toggle();
    run_xfer(13'h040, 13'h000, 11'h050, 6'd0, 13'd4, 6'd1, 1'b1, -1, -1, 30);
    checks++;
    if (hold_chk != 3 || hold_bad != 0) begin
      errors++; $display("FAIL t4_hold got chk=%0d bad=%0d exp 3/0", hold_chk, hold_bad);
    end
    checks++;
    if (wr_a.size() != 4) begin errors++; $display("FAIL t4_nwr got %0d exp 4", wr_a.size()); end
    for (int i = 0; i < wr_a.size() && i < 4; i++) begin
      checks++;
      if (wr_a[i] !== 11'h050 + 11'(i) || wr_d[i] !== 64'hA40 + 64'(i) || wr_c[i] != 3 + 2 * i) begin
        errors++; $display("FAIL t4_wr%0d got %0h:%0h@%0d exp %0h:%0h@%0d", i, wr_a[i], wr_d[i], wr_c[i],
                           11'h050 + 11'(i), 64'hA40 + 64'(i), 3 + 2 * i);
      end
    end
    checks++;
    if (done_c != 10) begin errors++; $display("FAIL t4_done got %0d exp 10", done_c); end
  endtask

  task automatic test_empty_and_ovr();
    run_xfer(13'h010, 13'h000, 11'h020, 6'd0, 13'd0, 6'd3, 1'b0, -1, -1, 10);
    checks++;
    if (rd_a.size() != 0 || wr_a.size() != 0 || busy_m !== 64'h2 || done_c != 2) begin
      errors++; $display("FAIL t5_len0 got rd=%0d wr=%0d busy=%0h done@%0d exp 0/0/2/2", rd_a.size(), wr_a.size(), busy_m, done_c);
    end
`ifdef DLA_MOV_GB2LB_PERF_EN
    checks++;
    if (perf_cycles !== 16'd2) begin errors++; $display("FAIL t5_perf got %0d exp 2", perf_cycles); end
`endif
    run_xfer(13'h010, 13'h000, 11'h020, 6'd0, 13'd5, 6'd0, 1'b0, -1, -1, 10);
    checks++;
    if (rd_a.size() != 0 || wr_a.size() != 0 || busy_m !== 64'h2 || done_c != 2) begin
      errors++; $display("FAIL t5_iter0 got rd=%0d wr=%0d busy=%0h done@%0d exp 0/0/2/2", rd_a.size(), wr_a.size(), busy_m, done_c);
    end
    run_xfer(13'h010, 13'h000, 11'h020, 6'd0, 13'd4, 6'd1, 1'b0, 3, -1, 20);
    checks++;
    if (ovr_n != 1 || ovr_c != 3) begin errors++; $display("FAIL t5_ovr got n=%0d@%0d exp 1@3", ovr_n, ovr_c); end
    checks++;
    if (wr_a.size() != 4 || done_c != 7) begin
      errors++; $display("FAIL t5_xfer got wr=%0d done@%0d exp 4/7", wr_a.size(), done_c);
    end
    for (int i = 0; i < wr_a.size() && i < 4; i++) begin
      checks++;
      if (wr_a[i] !== 11'h020 + 11'(i) || wr_d[i] !== 64'hA10 + 64'(i)) begin
        errors++; $display("FAIL t5_wr%0d got %0h:%0h exp %0h:%0h", i, wr_a[i], wr_d[i], 11'h020 + 11'(i), 64'hA10 + 64'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle got busy=%b exp 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    run_xfer(13'h100, 13'h000, 11'h200, 6'd0, 13'd8, 6'd1, 1'b0, -1, 4, 9);
    checks++;
    if (snap !== 4'b0000) begin errors++; $display("FAIL t6_snap got %b exp 0000", snap); end
    checks++;
    if (rd_a.size() != 2 || wr_a.size() != 1 || done_c != -1) begin
      errors++; $display("FAIL t6_abort got rd=%0d wr=%0d done@%0d exp 2/1/-1", rd_a.size(), wr_a.size(), done_c);
    end
    checks++;
    if (wr_a.size() > 0 && (wr_a[0] !== 11'h200 || wr_d[0] !== 64'hB00 || wr_c[0] != 3)) begin
      errors++; $display("FAIL t6_wr0 got %0h:%0h@%0d exp 200:b00@3", wr_a[0], wr_d[0], wr_c[0]);
    end
    checks++;
    if (perf_cycles !== 16'd0) begin errors++; $display("FAIL t6_perf_rst got %0d exp 0", perf_cycles); end
    run_xfer(13'h100, 13'h000, 11'h200, 6'd0, 13'd8, 6'd1, 1'b0, -1, -1, 20);
    checks++;
    if (wr_a.size() != 8 || done_c != 11) begin
      errors++; $display("FAIL t6_rerun got wr=%0d done@%0d exp 8/11", wr_a.size(), done_c);
    end
    for (int i = 0; i < wr_a.size() && i < 8; i++) begin
      checks++;
      if (wr_a[i] !== 11'h200 + 11'(i) || wr_d[i] !== 64'hB00 + 64'(i) || wr_c[i] != i + 3) begin
        errors++; $display("FAIL t6_wr%0d got %0h:%0h@%0d exp %0h:%0h@%0d", i, wr_a[i], wr_d[i], wr_c[i],
                           11'h200 + 11'(i), 64'hB00 + 64'(i), i + 3);
      end
    end
`ifdef DLA_MOV_GB2LB_PERF_EN
    checks++;
    if (perf_cycles !== 16'd11) begin errors++; $display("FAIL t6_perf got %0d exp 11", perf_cycles); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    go_mov_gb2lb = 1'b0; gb_gnt = 1'b0; gb_rdata = '0;
    stgr_gb2lb_gb_addr = '0; stgr_gb2lb_gb_skip = '0; stgr_gb2lb_lb_addr = '0;
    stgr_gb2lb_lb_skip = '0; stgr_gb2lb_len = '0; stgr_gb2lb_iter = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_multi_row();
    test_wrap();
    test_gnt_toggle();
    test_empty_and_ovr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dla_mov_gb2lb.md
Name: dla_mov_gb2lb

Overview:
Move engine that carries out a GB→LB transfer once the register interface fires its go pulse. It consumes the go pulse and staged parameters: GB start address, GB row skip, LB start address, LB row skip, row length and row count. It issues global-buffer reads through a grant handshake and writes the returned words into the local buffer. The block sits between the DLA register interface, the GB read-port arbiter and an LB write port.

Parameters:
DW, 64, data word width of GB read data and LB write data
PERF_W, 16, width of the optional cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
go_mov_gb2lb  in  1  start pulse from register interface
stgr_gb2lb_gb_addr  in  13  GB start address
stgr_gb2lb_gb_skip  in  13  GB row-to-row address stride
stgr_gb2lb_lb_addr  in  11  LB start address
stgr_gb2lb_lb_skip  in  6  LB row-to-row address stride
stgr_gb2lb_len  in  13  words per row
stgr_gb2lb_iter  in  6  number of rows
gb_ren  out  1  GB read request
gb_gnt  in  1  GB read grant; a read is accepted when gb_ren && gb_gnt
gb_raddr  out  13  GB read address
gb_rdata  in  DW  GB read data, valid exactly 1 cycle after accept
lb_wen  out  1  LB write enable
lb_waddr  out  11  LB write address
lb_wdata  out  DW  LB write data
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
ovr  out  1  one-cycle pulse: go ignored because engine busy
perf_cycles  out  PERF_W  cycles of last transfer (optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, in-flight read discarded, no LB write issued. Applies equally mid-transfer.
- Staging registers update on the same edge that samples go. Parameters are therefore captured one cycle later, in LOAD.
- States:
  - IDLE/DONE: go=1 → LOAD.
  - LOAD: latch all parameters into working regs; row_gb=gb_addr, row_lb=lb_addr, wcnt=0, rcnt=0. If len==0 or iter==0 → DONE; else → RUN.
  - RUN: gb_ren=1, gb_raddr=row_gb+wcnt (mod 2^13). On accept: wcnt++. If wcnt==len-1 then wcnt=0, rcnt++, row_gb+=gb_skip (mod 2^13), row_lb+=lb_skip (mod 2^11, skip zero-extended). If this was the last word of the last row → DRAIN. No accept: hold address and counters.
  - DRAIN: one cycle for the final write → DONE.
  - DONE: done=1 for one cycle → IDLE, or → LOAD if go.
- busy=1 in LOAD, RUN and DRAIN; 0 in IDLE and DONE.
- Write path: the cycle after each accept, lb_wen=1, lb_wdata=gb_rdata, lb_waddr=row_lb+wcnt (mod 2^11). Address comes from a 1-stage pipeline register captured at accept. lb_wen=0 otherwise; lb_waddr/lb_wdata hold their last value.
- Total words N=len*iter; order is row-major with no duplicates or drops.
- Timing with gb_gnt always 1 and go at cycle 0:
  - LOAD at cycle 1.
  - Reads at cycles 2..N+1.
  - Writes at cycles 3..N+2.
  - done at cycle N+3.
- go while busy: ignored, ovr=1 same cycle, transfer unaffected.
- Parameter changes on stgr_* while busy have no effect.

Optional Feature:
Macro DLA_MOV_GB2LB_PERF_EN.
- Defined: counter cleared in LOAD, increments every cycle while busy or done. perf_cycles latches the final count at DONE, which equals go-to-done distance (N+3 with full grant) and saturates at 2^PERF_W-1. perf_cycles holds until next DONE; reset 0.
- Undefined: no counter logic; perf_cycles tied 0.

Test Plan:
1. gb_addr=0x010, lb_addr=0x020, len=4, iter=1, gnt=1, rdata=addr+0xA00 → reads 0x010..0x013 at cycles 2-5; writes 0x020..0x023 with data 0xA10..0xA13 at cycles 3-6; done at 7; perf_cycles=7 if enabled.
2. gb_addr=0, gb_skip=0x100, lb_addr=0, lb_skip=8, len=3, iter=2 → GB reads 0,1,2,0x100,0x101,0x102; LB writes 0,1,2,8,9,10; done at cycle 9.
3. Wrap: gb_addr=0x1FFE, lb_addr=0x7FF, len=4, iter=1 → GB reads 0x1FFE,0x1FFF,0x0000,0x0001; LB writes 0x7FF,0x000,0x001,0x002.
4. len=4, iter=1, gb_gnt toggling 1,0,1,0… → gb_raddr held while ungranted; exactly 4 writes in order; done 1 cycle after the DRAIN that follows the 4th accept.
5. len=0 or iter=0 → no gb_ren, no lb_wen, busy only at cycle 1, done at cycle 2. Second go at cycle 3 of an active transfer → ovr=1 at cycle 3; original transfer completes unchanged.
6. rst asserted mid-RUN at word 2 of 8 → busy/gb_ren/lb_wen/done low immediately; no further writes. New go after release runs a full correct transfer.
